ax_rt_budget_sched: RTL and testbench

Budget-aware round-robin scheduler that shares one downstream AX (AW or AR) channel between NumMgr requesting managers. Each manager has its own RT budget/period counter instance. The block gates every manager whose counter reports the budget spent, or which is being isolated. It pulses the per-manager ax_happening_o feedback so the counters decrement by the granted transfer's byte count. It sits between the manager-side AX channels and the shared subordinate port inside the RT unit.

---
 rtl/ax_rt_sched_pkg.sv | 23 ++
 rtl/ax_rt_rr_pick.sv | 39 +++
 rtl/ax_rt_budget_sched.sv | 157 +++++++++++++++
 tb/tb_ax_rt_budget_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ax_rt_sched_pkg.sv
// ============================================================================
// Module   : ax_rt_sched_pkg
// Purpose  : Shared types, constants and helpers for the RT budget scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ax_rt_sched_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    localparam int StallCntWidth = 16;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_mgr);
        return ((idx + 32'd1) >= num_mgr) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ax_rt_rr_pick.sv
// ============================================================================
// Module   : ax_rt_rr_pick
// Purpose  : Combinational round-robin pick: first eligible index at or after
//            the pointer, wrapping modulo NumMgr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ax_rt_rr_pick #(
    parameter int NumMgr   = 4,
    parameter int IdxWidth = $clog2(NumMgr)
) (
    input  logic [NumMgr-1:0]   i_elig,
    input  logic [IdxWidth-1:0] i_rr,
    output logic [IdxWidth-1:0] o_winner,
    output logic                o_any
);

    logic [IdxWidth:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NumMgr; k++) begin
            w_idx = {1'b0, i_rr} + (IdxWidth+1)'(k);
            if (w_idx >= (IdxWidth+1)'(NumMgr)) begin
                w_idx = w_idx - (IdxWidth+1)'(NumMgr);
            end
            if (!o_any && i_elig[w_idx[IdxWidth-1:0]]) begin
                o_any    = 1'b1;
                o_winner = w_idx[IdxWidth-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ax_rt_budget_sched.sv
// ============================================================================
// Module   : ax_rt_budget_sched
// Purpose  : Budget-aware round-robin scheduler sharing one AX channel among
//            NumMgr managers. Optional stall counters: AXI_RT_SCHED_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ax_rt_budget_sched
    import ax_rt_sched_pkg::*;
#(
    parameter int  NumMgr       = 4,
    parameter int  AxBytesWidth = 16,
    parameter type ax_bytes_t   = logic [AxBytesWidth-1:0],
    parameter int  IdxWidth     = $clog2(NumMgr)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [NumMgr-1:0]         mgr_valid_i,
    output logic [NumMgr-1:0]         mgr_ready_o,
    input  ax_bytes_t [NumMgr-1:0]    mgr_bytes_i,
    input  logic [NumMgr-1:0]         budget_spent_i,
    output logic [NumMgr-1:0]         ax_happening_o,
    output ax_bytes_t [NumMgr-1:0]    ax_bytes_o,
    input  logic [NumMgr-1:0]         isolate_i,
    output logic [NumMgr-1:0]         isolated_o,
    output logic                      sub_valid_o,
    input  logic                      sub_ready_i,
    output logic [IdxWidth-1:0]       sub_idx_o,
    output ax_bytes_t                 sub_bytes_o
`ifdef AXI_RT_SCHED_STALL_CNT_EN
    ,
    input  logic [NumMgr-1:0]                    stall_clr_i,
    output logic [NumMgr-1:0][StallCntWidth-1:0] stall_cnt_o
`endif
);

    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic [IdxWidth-1:0] r_rr;
    logic [IdxWidth-1:0] w_rr_nxt;
    logic [IdxWidth-1:0] r_lock_idx;
    logic [IdxWidth-1:0] w_lock_nxt;
    logic [NumMgr-1:0]   r_isolated;
    logic [NumMgr-1:0]   w_iso_nxt;
    logic [NumMgr-1:0]   w_elig;
    logic [IdxWidth-1:0] w_winner;
    logic                w_any;

    assign w_elig = {NumMgr{enable_i}} & mgr_valid_i & ~budget_spent_i & ~isolate_i;

    ax_rt_rr_pick #(
        .NumMgr   (NumMgr),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .i_elig   (w_elig),
        .i_rr     (r_rr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Once a request is presented without a handshake it is locked and held
    // regardless of budget, isolation or enable so valid is never withdrawn.
    always_comb begin
        sub_valid_o = 1'b0;
        sub_idx_o   = '0;
        sub_bytes_o = '0;
        mgr_ready_o = '0;
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_lock_nxt  = r_lock_idx;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    sub_valid_o           = 1'b1;
                    sub_idx_o             = w_winner;
                    sub_bytes_o           = mgr_bytes_i[w_winner];
                    mgr_ready_o[w_winner] = sub_ready_i;
                    if (sub_ready_i) begin
                        w_rr_nxt = IdxWidth'(rr_next(32'(w_winner), NumMgr));
                    end else begin
                        w_state_nxt = LOCKED;
                        w_lock_nxt  = w_winner;
                    end
                end
            end
            LOCKED: begin
                sub_valid_o             = 1'b1;
                sub_idx_o               = r_lock_idx;
                sub_bytes_o             = mgr_bytes_i[r_lock_idx];
                mgr_ready_o[r_lock_idx] = sub_ready_i;
                if (sub_ready_i) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = IdxWidth'(rr_next(32'(r_lock_idx), NumMgr));
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ax_happening_o = mgr_valid_i & mgr_ready_o;
    assign ax_bytes_o     = mgr_bytes_i;

    // A manager only reports isolated once it has no request stalled on the port.
    always_comb begin
        w_iso_nxt = '0;
        for (int i = 0; i < NumMgr; i++) begin
            w_iso_nxt[i] = isolate_i[i] &
                           ~(sub_valid_o & (sub_idx_o == IdxWidth'(i)) & ~sub_ready_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_lock_idx <= '0;
            r_isolated <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_lock_idx <= w_lock_nxt;
            r_isolated <= w_iso_nxt;
        end
    end

    assign isolated_o = r_isolated;

`ifdef AXI_RT_SCHED_STALL_CNT_EN
    logic [NumMgr-1:0][StallCntWidth-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NumMgr; i++) begin
                if (stall_clr_i[i]) begin
                    r_stall_cnt[i] <= '0;
                end else if (mgr_valid_i[i] & budget_spent_i[i] & ~isolate_i[i] &
                             ~(&r_stall_cnt[i])) begin
                    r_stall_cnt[i] <= r_stall_cnt[i] + StallCntWidth'(1);
                end
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    // Stall counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ax_rt_budget_sched.sv
// ============================================================================
// Module   : tb_ax_rt_budget_sched
// Purpose  : Directed self-checking bench for ax_rt_budget_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ax_rt_budget_sched;

    localparam int N  = 4;
    localparam int BW = 16;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b1;
    logic                 enable_i;
    logic [N-1:0]         mgr_valid_i;
    logic [N-1:0]         mgr_ready_o;
    logic [N-1:0][BW-1:0] mgr_bytes_i;
    logic [N-1:0]         budget_spent_i;
    logic [N-1:0]         ax_happening_o;
    logic [N-1:0][BW-1:0] ax_bytes_o;
    logic [N-1:0]         isolate_i;
    logic [N-1:0]         isolated_o;
    logic                 sub_valid_o;
    logic                 sub_ready_i;
    logic [1:0]           sub_idx_o;
    logic [BW-1:0]        sub_bytes_o;
`ifdef AXI_RT_SCHED_STALL_CNT_EN
    logic [N-1:0]         stall_clr_i;
    logic [N-1:0][15:0]   stall_cnt_o;
`endif

    logic [BW-1:0] c_bytes [N];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [N-1:0]  m_pend = '0;

    always #5 clk = ~clk;

    ax_rt_budget_sched #(
        .NumMgr       (N),
        .AxBytesWidth (BW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .mgr_valid_i    (mgr_valid_i),
        .mgr_ready_o    (mgr_ready_o),
        .mgr_bytes_i    (mgr_bytes_i),
        .budget_spent_i (budget_spent_i),
        .ax_happening_o (ax_happening_o),
        .ax_bytes_o     (ax_bytes_o),
        .isolate_i      (isolate_i),
        .isolated_o     (isolated_o),
        .sub_valid_o    (sub_valid_o),
        .sub_ready_i    (sub_ready_i),
        .sub_idx_o      (sub_idx_o),
        .sub_bytes_o    (sub_bytes_o)
`ifdef AXI_RT_SCHED_STALL_CNT_EN
        ,
        .stall_clr_i    (stall_clr_i),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    // Managers must hold valid until accepted.
    always @(negedge clk) begin
        if (rst_ni) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i]) begin
                    assert (mgr_valid_i[i]) else $error("manager %0d dropped valid before ready", i);
                end
            end
            m_pend <= mgr_valid_i & ~mgr_ready_o;
        end else begin
            m_pend <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        enable_i       = 1'b1;
        mgr_valid_i    = '0;
        budget_spent_i = '0;
        isolate_i      = '0;
        sub_ready_i    = 1'b0;
`ifdef AXI_RT_SCHED_STALL_CNT_EN
        stall_clr_i    = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            c_bytes[i]     = 16'h0100 + 16'(i * 16'h0011);
            mgr_bytes_i[i] = c_bytes[i];
        end
        enable_i       = 1'b1;
        mgr_valid_i    = '0;
        budget_spent_i = '0;
        isolate_i      = '0;
        sub_ready_i    = 1'b0;
`ifdef AXI_RT_SCHED_STALL_CNT_EN
        stall_clr_i    = '0;
`endif
        #1;
        rst_ni = 1'b0;
        #3;
        chk("rst_sub_valid", 32'(sub_valid_o), 32'd0);
        chk("rst_sub_idx", 32'(sub_idx_o), 32'd0);
        chk("rst_sub_bytes", 32'(sub_bytes_o), 32'd0);
        chk("rst_mgr_ready", 32'(mgr_ready_o), 32'd0);
        chk("rst_happening", 32'(ax_happening_o), 32'd0);
        chk("rst_isolated", 32'(isolated_o), 32'd0);

        // All valid, always ready: strict rotation 0,1,2,3,0.
        do_reset();
        mgr_valid_i = 4'hF;
        sub_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("rot_valid", 32'(sub_valid_o), 32'd1);
            chk("rot_idx", 32'(sub_idx_o), 32'(k % 4));
            chk("rot_bytes", 32'(sub_bytes_o), 32'(c_bytes[k % 4]));
            chk("rot_happening", 32'(ax_happening_o), 32'(1 << (k % 4)));
            cyc();
        end
        chk("bytes_passthru", 32'(ax_bytes_o[3]), 32'(c_bytes[3]));

        // Locked request survives budget_spent; no regrant afterwards.
        do_reset();
        mgr_valid_i = 4'b0010;
        #3;
        chk("lock_valid_c0", 32'(sub_valid_o), 32'd1);
        chk("lock_idx_c0", 32'(sub_idx_o), 32'd1);
        chk("lock_ready_c0", 32'(mgr_ready_o), 32'd0);
        cyc();
        budget_spent_i = 4'b0010;
        #3;
        chk("lock_valid_c1", 32'(sub_valid_o), 32'd1);
        chk("lock_idx_c1", 32'(sub_idx_o), 32'd1);
        cyc();
        #3;
        chk("lock_valid_c2", 32'(sub_valid_o), 32'd1);
        cyc();
        sub_ready_i = 1'b1;
        #3;
        chk("lock_hs_ready", 32'(mgr_ready_o), 32'b0010);
        chk("lock_hs_happening", 32'(ax_happening_o), 32'b0010);
        cyc();
        #3;
        chk("spent_no_grant", 32'(sub_valid_o), 32'd0);
        chk("spent_no_happening", 32'(ax_happening_o), 32'd0);

        // Managers 0 and 2 spent: only 1 and 3 alternate.
        do_reset();
        budget_spent_i = 4'b0101;
        mgr_valid_i    = 4'hF;
        sub_ready_i    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("spent_idx", 32'(sub_idx_o), (k % 2 == 1) ? 32'd3 : 32'd1);
            chk("spent_ready", 32'(mgr_ready_o), (k % 2 == 1) ? 32'b1000 : 32'b0010);
            cyc();
        end

        // Isolation requested while manager 2 is locked.
        do_reset();
        mgr_valid_i = 4'b0100;
        #3;
        chk("iso_lock_idx", 32'(sub_idx_o), 32'd2);
        cyc();
        isolate_i = 4'b0100;
        #3;
        chk("iso_locked_valid", 32'(sub_valid_o), 32'd1);
        chk("iso_locked_idx", 32'(sub_idx_o), 32'd2);
        chk("iso_pending_0", 32'(isolated_o), 32'd0);
        cyc();
        sub_ready_i = 1'b1;
        #3;
        chk("iso_hs_isolated", 32'(isolated_o), 32'd0);
        chk("iso_hs_happening", 32'(ax_happening_o), 32'b0100);
        cyc();
        mgr_valid_i = 4'b0101;
        #3;
        chk("iso_set", 32'(isolated_o), 32'b0100);
        chk("iso_skip_idx", 32'(sub_idx_o), 32'd0);
        chk("iso_skip_happening", 32'(ax_happening_o), 32'b0001);
        cyc();
        #3;
        chk("iso_skip2_ready", 32'(mgr_ready_o), 32'b0001);
        cyc();
        isolate_i = 4'b0000;
        #3;
        chk("iso_hold", 32'(isolated_o), 32'b0100);
        chk("iso_release_idx", 32'(sub_idx_o), 32'd2);
        cyc();
        #3;
        chk("iso_clear", 32'(isolated_o), 32'd0);

        // Enable gating and resume from saved pointer.
        do_reset();
        mgr_valid_i = 4'hF;
        sub_ready_i = 1'b1;
        #3;
        chk("en_first_idx", 32'(sub_idx_o), 32'd0);
        cyc();
        enable_i = 1'b0;
        #3;
        chk("en_off_valid", 32'(sub_valid_o), 32'd0);
        chk("en_off_ready", 32'(mgr_ready_o), 32'd0);
        cyc();
        #3;
        chk("en_off_valid2", 32'(sub_valid_o), 32'd0);
        cyc();
        enable_i = 1'b1;
        #3;
        chk("en_on_valid", 32'(sub_valid_o), 32'd1);
        chk("en_on_idx", 32'(sub_idx_o), 32'd1);
        cyc();
        sub_ready_i = 1'b0;
        #3;
        chk("en_lock_idx", 32'(sub_idx_o), 32'd2);
        cyc();
        enable_i = 1'b0;
        #3;
        chk("en_locked_valid", 32'(sub_valid_o), 32'd1);
        chk("en_locked_idx", 32'(sub_idx_o), 32'd2);
        cyc();
        sub_ready_i = 1'b1;
        #3;
        chk("en_locked_hs", 32'(ax_happening_o), 32'b0100);
        cyc();
        #3;
        chk("en_off_after", 32'(sub_valid_o), 32'd0);

        // Reset mid-transfer drops the locked request immediately.
        enable_i    = 1'b1;
        sub_ready_i = 1'b0;
        cyc();
        #3;
        chk("mid_locked", 32'(sub_valid_o), 32'd1);
        rst_ni      = 1'b0;
        mgr_valid_i = '0;
        #1;
        chk("mid_rst_valid", 32'(sub_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(mgr_ready_o), 32'd0);

`ifdef AXI_RT_SCHED_STALL_CNT_EN
        do_reset();
        mgr_valid_i    = 4'b0001;
        budget_spent_i = 4'b0001;
        repeat (10) cyc();
        #3;
        chk("stall_10", 32'(stall_cnt_o[0]), 32'd10);
        chk("stall_other", 32'(stall_cnt_o[1]), 32'd0);
        cyc();
        stall_clr_i = 4'b0001;
        cyc();
        stall_clr_i = 4'b0000;
        #3;
        chk("stall_clr", 32'(stall_cnt_o[0]), 32'd0);
        repeat (70000) cyc();
        #3;
        chk("stall_sat", 32'(stall_cnt_o[0]), 32'd65535);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
